morse_key_decoder: RTL and testbench
====================================

Name: morse_key_decoder

Overview:
Converts the operator's raw Morse key (push-button) level into timed Morse events: dot/dash symbols, letter boundaries and word boundaries. It is the measuring end of the design's timebase. It consumes the divided 25 MHz system clock and counts key mark/space durations in "time units" of TICK_DIV clock cycles. It feeds the character lookup and display logic downstream.

Parameters:
TICK_DIV, 2500000, clk cycles per Morse time unit (100 ms at 25 MHz); must be >= 2
CNT_W, 4, width of the unit counter; counter saturates at 2^CNT_W-1
DASH_UNITS, 2, a mark of >= DASH_UNITS units is a dash; 1..DASH_UNITS-1 is a dot
LETTER_GAP_UNITS, 3, space length that ends a letter
WORD_GAP_UNITS, 7, space length that ends a word; must be > LETTER_GAP_UNITS and < 2^CNT_W

Ports:
clk  in  1  system clock (25 MHz divided clock)
reset  in  1  asynchronous, active-high reset
key_in  in  1  raw key level, asynchronous to clk, 1 = pressed
sym_valid  out  1  one-cycle pulse: a symbol was completed
sym_is_dash  out  1  symbol type, valid with sym_valid (1 = dash, 0 = dot)
sym_units  out  CNT_W  measured mark length in units, valid with sym_valid
letter_end  out  1  one-cycle pulse: letter gap reached
word_end  out  1  one-cycle pulse: word gap reached
key_active  out  1  registered synchronized key level (for an LED)

Behaviour:
- Decided: one clock, clk. reset is asynchronous and active-high. All flops clear immediately on reset assertion.
- Reset values: all outputs 0, state IDLE, synchronizer flops 0, tick and unit counters 0.
- key_in passes through a 2-flop synchronizer to give key_s. key_active = key_s. Edges are detected against a third registered copy of key_s.
- Tick prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle when the count equals TICK_DIV-1, then wraps to 0. It is cleared on every state entry.
- Unit counter: increments on tick and saturates at 2^CNT_W-1. It is cleared on every state entry.
- State IDLE: no key activity and the word gap has already been reported. Counters are held at 0. A key_s rising edge moves to MARK.
- State MARK (key held):
  - On a key_s falling edge, with units >= 1: pulse sym_valid with sym_units = units and sym_is_dash = (units >= DASH_UNITS), then go to SPACE.
  - On a key_s falling edge, with units == 0: the press is a glitch. Go to SPACE with no sym_valid.
  - Holding the key past saturation still yields a dash with sym_units = 2^CNT_W-1.
- State SPACE (key released):
  - On the tick that makes units == LETTER_GAP_UNITS: pulse letter_end once.
  - On the tick that makes units == WORD_GAP_UNITS: pulse word_end and go to IDLE.
  - A key_s rising edge goes to MARK. If letter_end has not fired yet, the new symbol belongs to the same letter and no letter_end is emitted.
- A glitch that follows a completed symbol returns to SPACE with counters cleared. This extends the gap; it is not an error.
- Outputs are registered, and every pulse is exactly one cycle. sym_valid and letter_end/word_end can never coincide. letter_end and word_end never fire in the same cycle.
- Latency: sym_valid is high during the 3rd cycle after the first clk edge that samples key_in low. Gap pulses follow the same 3-cycle synchronizer offset relative to key_in.
- Reset mid-operation: returns to IDLE and drops any partial symbol. Nothing pulses on reset release.
- Unit count is measured from the first key_s cycle in a state: a mark of N clk cycles gives units = floor(N/TICK_DIV), saturated.

Decomposition:
- Shared package morse_pkg holds:
  - the state enum (IDLE, MARK, SPACE)
  - default timing constants: TICK_DIV_25MHZ, DASH_UNITS, LETTER_GAP_UNITS, WORD_GAP_UNITS
  - the symbol type encoding (DOT = 0, DASH = 1)
- One sub-module, morse_unit_tick: the clearable TICK_DIV prescaler, with ports clk, reset, clr, tick.
- The synchronizer and FSM stay in the top module.

Test Plan (TICK_DIV=4, CNT_W=4, defaults otherwise):
- key_in high for 6 cycles, then low -> one sym_valid, sym_is_dash=0, sym_units=1, 3 cycles after the release edge.
- key_in high for 9 cycles -> sym_valid, sym_is_dash=1, sym_units=2. Then low for 30 cycles -> letter_end 12 cycles after sym_valid, word_end 28 cycles after sym_valid, then IDLE with no further pulses.
- key_in high for 3 cycles (glitch) -> no sym_valid. A following 20-cycle space gives a letter_end pulse only.
- Dot, 6-cycle space, dot -> two sym_valid pulses with no letter_end between them. letter_end follows after the second dot.
- key held 100 cycles -> sym_units=15, sym_is_dash=1.
- reset asserted asynchronously mid-MARK (between clk edges) -> outputs 0 immediately. After release, a 6-cycle press gives a normal dot; no stale pulses appear.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the Morse key decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package morse_pkg;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // Symbol type as reported on sym_is_dash
  typedef enum logic {
    DOT  = 1'b0,
    DASH = 1'b1
  } sym_t;

  // Default timing: 100 ms time unit at 25 MHz
  localparam int TICK_DIV_25MHZ       = 2500000;
  localparam int DEF_DASH_UNITS       = 2;
  localparam int DEF_LETTER_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS   = 7;

endpackage

// File: rtl/morse_unit_tick.sv
// Clearable prescaler: one-cycle tick every TICK_DIV clocks (one Morse time unit).
// Latency: tick is decoded from the count register, so it is high while count == TICK_DIV-1.
// Backpressure: none; free-running unless cleared.
//
// Ports:
//   i_clk   - system clock
//   i_reset - asynchronous active-high reset
//   i_clr   - synchronous clear, count restarts at 0 on the next cycle
//   o_tick  - one-cycle pulse when the count reaches TICK_DIV-1
module morse_unit_tick
  import morse_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_25MHZ
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW     = $clog2(TICK_DIV);
  localparam logic [CW-1:0] L_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == L_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == L_LAST);

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: turns raw key level into dot/dash, letter-gap and word-gap events.
// Latency: sym_valid is high in the 3rd cycle after the first edge that samples the key released.
// Backpressure: none; all outputs are single-cycle pulses that downstream must take.
//
// Ports:
//   i_clk, i_reset   - clock, asynchronous active-high reset
//   i_key_in         - raw key level (async), 1 = pressed
//   o_sym_valid      - one-cycle pulse, a symbol completed
//   o_sym_is_dash    - 1 = dash, 0 = dot (with o_sym_valid)
//   o_sym_units      - measured mark length in units (with o_sym_valid)
//   o_letter_end     - one-cycle pulse, letter gap reached
//   o_word_end       - one-cycle pulse, word gap reached
//   o_key_active     - synchronized key level
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV         = TICK_DIV_25MHZ,
  parameter int CNT_W            = 4,
  parameter int DASH_UNITS       = DEF_DASH_UNITS,
  parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
  parameter int WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_key_in,
  output logic             o_sym_valid,
  output logic             o_sym_is_dash,
  output logic [CNT_W-1:0] o_sym_units,
  output logic             o_letter_end,
  output logic             o_word_end,
  output logic             o_key_active
);

  localparam logic [CNT_W-1:0] L_MAX  = '1;
  localparam logic [CNT_W-1:0] L_DASH = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] L_LG   = CNT_W'(LETTER_GAP_UNITS);
  localparam logic [CNT_W-1:0] L_WG   = CNT_W'(WORD_GAP_UNITS);

  // Synchronizer plus one extra copy for edge detection
  logic r_sync_meta;
  logic r_key_s;
  logic r_key_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync_meta <= 1'b0;
      r_key_s     <= 1'b0;
      r_key_d     <= 1'b0;
    end else begin
      r_sync_meta <= i_key_in;
      r_key_s     <= r_sync_meta;
      r_key_d     <= r_key_s;
    end
  end

  logic w_rise;
  logic w_fall;
  assign w_rise = r_key_s & ~r_key_d;
  assign w_fall = ~r_key_s & r_key_d;

  state_t           r_state;
  logic [CNT_W-1:0] r_units;
  logic             r_sym_valid;
  logic             r_sym_is_dash;
  logic [CNT_W-1:0] r_sym_units;
  logic             r_letter_end;
  logic             r_word_end;

  logic             w_tick;
  logic             w_clr;
  logic [CNT_W-1:0] w_units_nxt;

  // Unit count including this cycle's tick. Using it for decisions lets the
  // edge-detect cycle stand in for the cycle lost to the state-entry clear,
  // so a mark of N cycles measures floor(N/TICK_DIV) units.
  assign w_units_nxt = (w_tick && (r_units != L_MAX)) ? r_units + 1'b1 : r_units;

  // Counters restart on every state change and are parked at 0 in IDLE
  always_comb begin
    w_clr = 1'b0;
    case (r_state)
      IDLE:    w_clr = 1'b1;
      MARK:    w_clr = w_fall;
      SPACE:   w_clr = w_rise | (w_tick & (w_units_nxt == L_WG));
      default: w_clr = 1'b1;
    endcase
  end

  morse_unit_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_units       <= '0;
      r_sym_valid   <= 1'b0;
      r_sym_is_dash <= 1'b0;
      r_sym_units   <= '0;
      r_letter_end  <= 1'b0;
      r_word_end    <= 1'b0;
    end else begin
      r_sym_valid  <= 1'b0;
      r_letter_end <= 1'b0;
      r_word_end   <= 1'b0;
      r_units      <= w_clr ? '0 : w_units_nxt;
      case (r_state)
        IDLE: begin
          if (w_rise) r_state <= MARK;
        end
        MARK: begin
          if (w_fall) begin
            // A zero-unit press is a glitch: no symbol, but the gap restarts
            if (w_units_nxt != '0) begin
              r_sym_valid   <= 1'b1;
              r_sym_units   <= w_units_nxt;
              r_sym_is_dash <= (w_units_nxt >= L_DASH) ? DASH : DOT;
            end
            r_state <= SPACE;
          end
        end
        SPACE: begin
          // A new press wins over a gap tick in the same cycle
          if (w_rise) begin
            r_state <= MARK;
          end else if (w_tick) begin
            if (w_units_nxt == L_LG) r_letter_end <= 1'b1;
            if (w_units_nxt == L_WG) begin
              r_word_end <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sym_valid   = r_sym_valid;
  assign o_sym_is_dash = r_sym_is_dash;
  assign o_sym_units   = r_sym_units;
  assign o_letter_end  = r_letter_end;
  assign o_word_end    = r_word_end;
  assign o_key_active  = r_key_s;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Testbench for morse_key_decoder with a short time unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_morse_key_decoder;

  localparam int TD  = 4;
  localparam int CW  = 4;
  localparam int DU  = 2;
  localparam int LG  = 3;
  localparam int WG  = 7;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_in;
  logic          sym_valid;
  logic          sym_is_dash;
  logic [CW-1:0] sym_units;
  logic          letter_end;
  logic          word_end;
  logic          key_active;

  always #5 clk = ~clk;

  morse_key_decoder #(
    .TICK_DIV         (TD),
    .CNT_W            (CW),
    .DASH_UNITS       (DU),
    .LETTER_GAP_UNITS (LG),
    .WORD_GAP_UNITS   (WG)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_key_in      (key_in),
    .o_sym_valid   (sym_valid),
    .o_sym_is_dash (sym_is_dash),
    .o_sym_units   (sym_units),
    .o_letter_end  (letter_end),
    .o_word_end    (word_end),
    .o_key_active  (key_active)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: key level history as run lengths
  bit m_s1, m_ks, m_kd, m_armed;
  int m_run, m_prev;
  bit e_sym, e_dash, e_let, e_word, e_act;
  int e_units;

  // Observed event statistics
  int n_sym, n_let, n_word;
  int last_sym_cyc, last_let_cyc, last_word_cyc, last_units;
  bit last_dash;

  typedef struct {
    int hi;
    int exp_sym;
    int exp_dash;
    int exp_units;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_ks = 0; m_kd = 0; m_armed = 0;
    m_run = 0; m_prev = 0;
    e_sym = 0; e_dash = 0; e_let = 0; e_word = 0; e_act = 0; e_units = 0;
  endtask

  // Outputs registered at this edge come from the current key_s history:
  // a finished mark of N cycles is floor(N/TD) units (saturated); gap pulses
  // fire once key_s has been low for k*TD+1 cycles after a mark.
  task automatic model_edge(input logic kin, input logic rst);
    int u;
    bit nk;
    if (rst) begin
      model_reset();
      return;
    end
    e_sym = 0; e_dash = 0; e_let = 0; e_word = 0; e_units = 0;
    if (!m_ks && m_kd) begin
      u = m_prev / TD;
      if (u > SAT) u = SAT;
      if (u >= 1) begin
        e_sym   = 1;
        e_units = u;
        e_dash  = (u >= DU);
      end
      m_armed = 1;
    end else if (!m_ks && m_armed) begin
      if (m_run == LG * TD + 1) e_let = 1;
      if (m_run == WG * TD + 1) begin
        e_word  = 1;
        m_armed = 0;
      end
    end
    nk = m_s1;
    if (nk != m_ks) begin
      m_prev = m_run;
      m_run  = 1;
    end else begin
      m_run++;
    end
    m_kd  = m_ks;
    m_ks  = nk;
    m_s1  = kin;
    e_act = m_ks;
  endtask

  task automatic clear_stats();
    n_sym = 0; n_let = 0; n_word = 0;
    last_sym_cyc = -1; last_let_cyc = -1; last_word_cyc = -1;
    last_units = -1; last_dash = 0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(key_in, reset);
    #1;
    check("sym_valid", 32'(sym_valid), 32'(e_sym));
    if (e_sym) begin
      check("sym_units", 32'(sym_units), 32'(e_units));
      check("sym_is_dash", 32'(sym_is_dash), 32'(e_dash));
    end
    check("letter_end", 32'(letter_end), 32'(e_let));
    check("word_end", 32'(word_end), 32'(e_word));
    check("key_active", 32'(key_active), 32'(e_act));
    if (sym_valid === 1'b1) begin
      n_sym++;
      last_sym_cyc = cyc;
      last_units   = int'(sym_units);
      last_dash    = sym_is_dash;
    end
    if (letter_end === 1'b1) begin
      n_let++;
      last_let_cyc = cyc;
    end
    if (word_end === 1'b1) begin
      n_word++;
      last_word_cyc = cyc;
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) step();
  endtask

  vec_t vecs[10];
  int   rel;

  initial begin
    vecs[0] = '{hi: 6,   exp_sym: 1, exp_dash: 0, exp_units: 1};
    vecs[1] = '{hi: 9,   exp_sym: 1, exp_dash: 1, exp_units: 2};
    vecs[2] = '{hi: 3,   exp_sym: 0, exp_dash: 0, exp_units: 0};
    vecs[3] = '{hi: 4,   exp_sym: 1, exp_dash: 0, exp_units: 1};
    vecs[4] = '{hi: 7,   exp_sym: 1, exp_dash: 0, exp_units: 1};
    vecs[5] = '{hi: 8,   exp_sym: 1, exp_dash: 1, exp_units: 2};
    vecs[6] = '{hi: 100, exp_sym: 1, exp_dash: 1, exp_units: 15};
    vecs[7] = '{hi: 1,   exp_sym: 0, exp_dash: 0, exp_units: 0};
    vecs[8] = '{hi: 63,  exp_sym: 1, exp_dash: 1, exp_units: 15};
    vecs[9] = '{hi: 12,  exp_sym: 1, exp_dash: 1, exp_units: 3};

    reset  = 1'b1;
    key_in = 1'b0;
    model_reset();
    clear_stats();
    #3;
    check("rst_sym_valid", 32'(sym_valid), 0);
    check("rst_sym_units", 32'(sym_units), 0);
    check("rst_sym_is_dash", 32'(sym_is_dash), 0);
    check("rst_letter_end", 32'(letter_end), 0);
    check("rst_word_end", 32'(word_end), 0);
    check("rst_key_active", 32'(key_active), 0);
    step();
    step();
    reset = 1'b0;
    hold(0, 4);

    // Table: isolated press from IDLE, then a long release
    for (int i = 0; i < 10; i++) begin
      clear_stats();
      hold(1, vecs[i].hi);
      rel = cyc + 1;
      hold(0, 40);
      check($sformatf("v%0d_nsym", i), 32'(n_sym), 32'(vecs[i].exp_sym));
      if (vecs[i].exp_sym != 0) begin
        check($sformatf("v%0d_units", i), 32'(last_units), 32'(vecs[i].exp_units));
        check($sformatf("v%0d_dash", i), 32'(last_dash), 32'(vecs[i].exp_dash));
        check($sformatf("v%0d_sym_lat", i), 32'(last_sym_cyc - rel), 2);
        check($sformatf("v%0d_let_dly", i), 32'(last_let_cyc - last_sym_cyc), 12);
        check($sformatf("v%0d_word_dly", i), 32'(last_word_cyc - last_sym_cyc), 28);
      end
      check($sformatf("v%0d_nlet", i), 32'(n_let), 1);
      check($sformatf("v%0d_nword", i), 32'(n_word), 1);
    end

    // Dot, short space, dot: one letter, after the second dot
    clear_stats();
    hold(1, 6);
    hold(0, 6);
    hold(1, 6);
    hold(0, 40);
    check("dd_nsym", 32'(n_sym), 2);
    check("dd_nlet", 32'(n_let), 1);
    check("dd_let_after_2nd", 32'(last_let_cyc - last_sym_cyc), 12);
    check("dd_nword", 32'(n_word), 1);

    // Asynchronous reset in the middle of a mark
    hold(1, 8);
    #2;
    reset = 1'b1;
    #1;
    check("arst_key_active", 32'(key_active), 0);
    check("arst_sym_valid", 32'(sym_valid), 0);
    check("arst_letter_end", 32'(letter_end), 0);
    check("arst_word_end", 32'(word_end), 0);
    model_reset();
    key_in = 1'b0;
    step();
    step();
    reset = 1'b0;
    clear_stats();
    hold(0, 5);
    check("arst_no_stale_sym", 32'(n_sym), 0);
    check("arst_no_stale_gap", 32'(n_let + n_word), 0);
    hold(1, 6);
    rel = cyc + 1;
    hold(0, 40);
    check("arst_nsym", 32'(n_sym), 1);
    check("arst_units", 32'(last_units), 1);
    check("arst_dash", 32'(last_dash), 0);
    check("arst_sym_lat", 32'(last_sym_cyc - rel), 2);

    // Random key activity, checked every cycle against the model
    for (int r = 0; r < 60; r++) begin
      hold(1, int'($urandom_range(1, 24)));
      hold(0, int'($urandom_range(1, 36)));
    end
    hold(0, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
